// File: rtl/init_req_sched.sv
// Round-robin request scheduler with ray-ID allocation for the init unit.
// Ports: clk, arst (async, active-high); req_vld/req_dat/req_rdy per-source
//   request streams; init_req_stream_rsc_{dat,vld,rdy} registered output
//   stream of {payload, rid}; cmp_vld/cmp_rid completion input;
//   cmp_src_vld/cmp_src owner report; inflight allocated count;
//   err_free sticky bad-free flag.
// Optional: define INIT_REQ_SCHED_STATS_EN to add stat_grant/stat_stall
//   saturating counters.
module init_req_sched #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 256,
  parameter int RID_WIDTH = 4,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OUT_W    = PAYLOAD_W + RID_WIDTH
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_dat,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [OUT_W-1:0]             init_req_stream_rsc_dat,
  output logic                         init_req_stream_rsc_vld,
  input  logic                         init_req_stream_rsc_rdy,
  input  logic                         cmp_vld,
  input  logic [RID_WIDTH-1:0]         cmp_rid,
  output logic                         cmp_src_vld,
  output logic [SRC_W-1:0]             cmp_src,
  output logic [RID_WIDTH:0]           inflight,
  output logic                         err_free
`ifdef INIT_REQ_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        stat_grant,
  output logic [31:0]                  stat_stall
`endif
);

  localparam int POOL = 1 << RID_WIDTH;

  logic [POOL-1:0]      alloc_q, alloc_d;
  logic [SRC_W-1:0]     owner_q [POOL];
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [OUT_W-1:0]     out_dat_q, out_dat_d;
  logic                 out_vld_q, out_vld_d;
  logic                 cmp_src_vld_q, cmp_src_vld_d;
  logic [SRC_W-1:0]     cmp_src_q, cmp_src_d;
  logic [RID_WIDTH:0]   inflight_q, inflight_d;
  logic                 err_q, err_d;

  logic                 pool_avail;
  logic                 can_issue;
  logic [RID_WIDTH-1:0] free_rid;
  logic                 gnt_vld;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W-1:0]     cand;
  logic [PAYLOAD_W-1:0] pay_sel;
  logic                 cmp_ok;

  assign pool_avail = ~&alloc_q;
  assign can_issue  = pool_avail &&
                      (!out_vld_q || init_req_stream_rsc_rdy);
  assign cmp_ok     = cmp_vld && alloc_q[cmp_rid];

  // Lowest-index free RID from the start-of-cycle bitmap, so a RID
  // freed this cycle is never re-issued in the same cycle.
  always_comb begin
    free_rid = '0;
    for (int r = POOL - 1; r >= 0; r--) begin
      if (!alloc_q[r]) free_rid = RID_WIDTH'(r);
    end
  end

  // Round-robin search starting just after the last granted source.
  // Reset also masks the grant so all outputs read 0 while held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_vld && req_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!can_issue || arst) gnt_vld = 1'b0;
  end

  always_comb begin
    req_rdy = '0;
    pay_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        req_rdy[i] = gnt_vld;
        pay_sel    = req_dat[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    alloc_d       = alloc_q;
    ptr_d         = ptr_q;
    out_dat_d     = out_dat_q;
    out_vld_d     = out_vld_q;
    cmp_src_vld_d = cmp_ok;
    cmp_src_d     = cmp_ok ? owner_q[cmp_rid] : '0;
    err_d         = err_q | (cmp_vld & ~alloc_q[cmp_rid]);
    inflight_d    = inflight_q
                  + (RID_WIDTH+1)'(gnt_vld)
                  - (RID_WIDTH+1)'(cmp_ok);
    if (cmp_ok) alloc_d[cmp_rid] = 1'b0;
    if (gnt_vld) begin
      alloc_d[free_rid] = 1'b1;
      ptr_d             = gnt_idx;
      out_dat_d         = {pay_sel, free_rid};
      out_vld_d         = 1'b1;
    end else if (init_req_stream_rsc_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      alloc_q       <= '0;
      ptr_q         <= SRC_W'(NUM_REQ - 1);
      out_dat_q     <= '0;
      out_vld_q     <= 1'b0;
      cmp_src_vld_q <= 1'b0;
      cmp_src_q     <= '0;
      inflight_q    <= '0;
      err_q         <= 1'b0;
      for (int r = 0; r < POOL; r++) owner_q[r] <= '0;
    end else begin
      alloc_q       <= alloc_d;
      ptr_q         <= ptr_d;
      out_dat_q     <= out_dat_d;
      out_vld_q     <= out_vld_d;
      cmp_src_vld_q <= cmp_src_vld_d;
      cmp_src_q     <= cmp_src_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
      if (gnt_vld) owner_q[free_rid] <= gnt_idx;
    end
  end

  assign init_req_stream_rsc_dat = out_dat_q;
  assign init_req_stream_rsc_vld = out_vld_q;
  assign cmp_src_vld             = cmp_src_vld_q;
  assign cmp_src                 = cmp_src_q;
  assign inflight                = inflight_q;
  assign err_free                = err_q;

`ifdef INIT_REQ_SCHED_STATS_EN
  logic [31:0] stat_grant_q [NUM_REQ];
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stat_stall_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) stat_grant_q[i] <= '0;
    end else begin
      if (|req_vld && !gnt_vld && !(&stat_stall_q))
        stat_stall_q <= stat_stall_q + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_rdy[i] && !(&stat_grant_q[i]))
          stat_grant_q[i] <= stat_grant_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      stat_grant[i*32 +: 32] = stat_grant_q[i];
  end

  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/init_req_sched.md
Name: init_req_sched

Overview:
- Round-robin scheduler that shares the single init unit among NUM_REQ ray-request sources.
- Allocates a ray ID (RID) from a free pool for each accepted request and appends it to the payload as {payload, rid}, RID in the LSBs.
- Drives init_req_stream_rsc_* through a one-entry output register.
- Reclaims RIDs on completion and reports which source owned each completed ray.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PAYLOAD_W, 256, ray payload width in bits (8x32).
- RID_WIDTH, 4, RID width; pool size 2**RID_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- req_vld  in  NUM_REQ  per-source request valid.
- req_dat  in  NUM_REQ*PAYLOAD_W  per-source payload; source i at bits [i*PAYLOAD_W +: PAYLOAD_W].
- req_rdy  out  NUM_REQ  one-hot grant; a transfer occurs when req_vld[i] & req_rdy[i].
- init_req_stream_rsc_dat  out  PAYLOAD_W+RID_WIDTH  {payload, rid} to the init unit.
- init_req_stream_rsc_vld  out  1  output valid.
- init_req_stream_rsc_rdy  in  1  init unit ready.
- cmp_vld  in  1  ray completion strobe.
- cmp_rid  in  RID_WIDTH  RID of the completed ray.
- cmp_src_vld  out  1  registered completion report.
- cmp_src  out  $clog2(NUM_REQ)  owner of the completed RID.
- inflight  out  RID_WIDTH+1  number of allocated RIDs.
- err_free  out  1  sticky; set on completion of an RID that is not allocated.

Behaviour:
- Reset (arst high, asynchronous): all outputs 0; all RIDs free; owner table cleared; RR pointer = NUM_REQ-1, so source 0 has first priority.
- can_issue = free pool non-empty AND (output register empty OR init_req_stream_rsc_rdy).
- Arbitration (combinational):
  - When can_issue, grant the first i with req_vld[i], searching from pointer+1 mod NUM_REQ.
  - req_rdy is one-hot or all-zero. req_rdy[i] may depend on req_vld (valid-ready, not ready-first).
  - No grant while the pool is empty or the output is stalled.
- Allocation:
  - The granted request takes the lowest-index free RID from the bitmap as it stood at the start of the cycle.
  - Next edge: bitmap bit set, owner[rid] = i, pointer = i, output register loaded with {req_dat slice, rid}, vld = 1.
  - Latency: grant in cycle N, init_req_stream_rsc_vld high in cycle N+1.
  - Full throughput of one request per cycle while init_req_stream_rsc_rdy stays high.
- Output register:
  - Holds dat and vld stable until the rdy handshake completes.
  - Handshake with no new grant clears vld.
  - Handshake with a new grant in the same cycle reloads the register; no bubble.
- Completion:
  - cmp_vld with an allocated cmp_rid clears the bit at the next edge.
  - Same edge: cmp_src_vld = 1 and cmp_src = owner[cmp_rid]. Both pulse for one cycle.
  - Completion of an unallocated RID: bitmap unchanged, cmp_src_vld = 0, err_free set until reset.
- Simultaneous alloc + free:
  - A RID freed in cycle N is allocatable from cycle N+1, never in cycle N.
  - inflight = allocations minus valid frees each cycle (+1, -1, or net 0).
- Pool boundaries:
  - inflight == 2**RID_WIDTH means the pool is empty; all req_rdy = 0.
  - After 2**RID_WIDTH-1 the allocation search wraps to RID 0 by lowest-free search; no counter overflow.
- Reset mid-operation: the in-flight output is dropped and all RIDs are freed; the init unit shares the same reset.

Optional Feature:
- Macro INIT_REQ_SCHED_STATS_EN.
- Defined:
  - Adds output stat_grant [NUM_REQ*32] holding per-source 32-bit grant counters.
  - Adds output stat_stall [32], counting cycles with any req_vld and no grant.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the stat ports are absent; no counter logic is built.

Test Plan:
- All 4 sources valid continuously, rdy=1, pool 16 → grants in order 0,1,2,3,0,…; RIDs 0,1,2,…,15; the 17th request stalls until a completion.
- Single source 2, payload 0xA5…A5, after reset → init_req_stream_rsc_dat = {0xA5…A5, 4'h0} one cycle after req_rdy[2]; inflight=1.
- rdy=0 for 5 cycles with vld=1 → dat stable, req_rdy=0 throughout; rdy=1 with source 1 valid → back-to-back transfer with no bubble.
- Pool full (inflight=16), cmp_rid=7 and a pending request in the same cycle → no grant that cycle; next cycle grant gets RID 7; cmp_src = owner of RID 7.
- cmp_vld with cmp_rid=3 never allocated → err_free=1 and sticky; inflight unchanged; cmp_src_vld=0.
- arst pulse mid-stream with inflight=9 → all outputs 0 immediately; after release, source 0 is granted first with RID 0.
